rv32_aludec_pipe: RTL and testbench

Registered, parametrised ALU decoder for the RV32 core. It takes instruction class strobes plus funct3/funct7 from the main decoder and emits one encoded 5-bit ALU operation, an immediate-select flag and an illegal-instruction flag. Decode covers optional RV32M. The result is held in a one-entry output buffer with valid/ready handshakes. M-extension ops are sequenced through a start/done handshake to the multi-cycle mul/div unit, guarded by a watchdog.

---
 rtl/rv32_alu_pkg.sv | 107 ++++++++++
 rtl/rv32_aludec_pipe_if.sv | 33 +++
 rtl/rv32_aludec_comb.sv | 67 ++++++
 rtl/rv32_aludec_pipe.sv | 99 +++++++++
 tb/tb_rv32_aludec_pipe.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_alu_pkg.sv
// Shared encodings for the RV32 ALU decoder: operation codes, funct3/funct7
// field values, FSM state encoding and small field-to-op helpers.
package rv32_alu_pkg;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t ALU_ADD    = 5'd0;
    localparam alu_op_t ALU_SUB    = 5'd1;
    localparam alu_op_t ALU_SLL    = 5'd2;
    localparam alu_op_t ALU_SLT    = 5'd3;
    localparam alu_op_t ALU_SLTU   = 5'd4;
    localparam alu_op_t ALU_XOR    = 5'd5;
    localparam alu_op_t ALU_SRL    = 5'd6;
    localparam alu_op_t ALU_SRA    = 5'd7;
    localparam alu_op_t ALU_OR     = 5'd8;
    localparam alu_op_t ALU_AND    = 5'd9;
    localparam alu_op_t ALU_BEQ    = 5'd10;
    localparam alu_op_t ALU_BNE    = 5'd11;
    localparam alu_op_t ALU_BLT    = 5'd12;
    localparam alu_op_t ALU_BGE    = 5'd13;
    localparam alu_op_t ALU_BLTU   = 5'd14;
    localparam alu_op_t ALU_BGEU   = 5'd15;
    localparam alu_op_t ALU_MUL    = 5'd16;
    localparam alu_op_t ALU_MULH   = 5'd17;
    localparam alu_op_t ALU_MULHSU = 5'd18;
    localparam alu_op_t ALU_MULHU  = 5'd19;
    localparam alu_op_t ALU_DIV    = 5'd20;
    localparam alu_op_t ALU_DIVU   = 5'd21;
    localparam alu_op_t ALU_REM    = 5'd22;
    localparam alu_op_t ALU_REMU   = 5'd23;
    localparam alu_op_t ALU_ILL    = 5'd31;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FULL    = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_t;

    // alt selects SUB over ADD and SRA over SRL; ignored for other funct3.
    function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        op = ALU_ILL;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_t branch_op(input logic [2:0] f3);
        alu_op_t op;
        op = ALU_ILL;
        case (f3)
            F3_BEQ:  op = ALU_BEQ;
            F3_BNE:  op = ALU_BNE;
            F3_BLT:  op = ALU_BLT;
            F3_BGE:  op = ALU_BGE;
            F3_BLTU: op = ALU_BLTU;
            F3_BGEU: op = ALU_BGEU;
            default: op = ALU_ILL;
        endcase
        return op;
    endfunction

    function automatic alu_op_t m_op(input logic [2:0] f3);
        alu_op_t op;
        op = ALU_ILL;
        case (f3)
            3'd0: op = ALU_MUL;
            3'd1: op = ALU_MULH;
            3'd2: op = ALU_MULHSU;
            3'd3: op = ALU_MULHU;
            3'd4: op = ALU_DIV;
            3'd5: op = ALU_DIVU;
            3'd6: op = ALU_REM;
            3'd7: op = ALU_REMU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_aludec_pipe_if.sv
// Decode request, result and mul/div sequencing signals of the ALU decoder.
// The core-side driver uses master; the decoder uses slave.
interface rv32_aludec_pipe_if;
    import rv32_alu_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       ar;
    logic       ar_i;
    logic       br;
    logic       lui_auipc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       out_valid;
    logic       out_ready;
    alu_op_t    alu_op;
    logic       op_rs2_imm;
    logic       illegal;
    logic       mc_start;
    logic       mc_done;
    logic       busy;

    modport master (
        output in_valid, ar, ar_i, br, lui_auipc, funct3, funct7, out_ready, mc_done,
        input  in_ready, out_valid, alu_op, op_rs2_imm, illegal, mc_start, busy
    );

    modport slave (
        input  in_valid, ar, ar_i, br, lui_auipc, funct3, funct7, out_ready, mc_done,
        output in_ready, out_valid, alu_op, op_rs2_imm, illegal, mc_start, busy
    );

endinterface

// File: rtl/rv32_aludec_comb.sv
// Purely combinational class/funct3/funct7 to ALU operation decode.
// Illegal encodings always come out as ALU_ILL with illegal set.
module rv32_aludec_comb
    import rv32_alu_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic       ar,
    input  logic       ar_i,
    input  logic       br,
    input  logic       lui_auipc,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_t    alu_op,
    output logic       is_m,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        alu_op  = ALU_ILL;
        is_m    = 1'b0;
        illegal = 1'b1;

        if ($onehot({ar, ar_i, br, lui_auipc})) begin
            if (lui_auipc) begin
                alu_op  = ALU_ADD;
                illegal = 1'b0;
            end else if (br) begin
                alu_op  = branch_op(funct3);
                illegal = (alu_op == ALU_ILL);
            end else if (ar) begin
                case (funct7)
                    F7_BASE: begin
                        alu_op  = base_op(funct3, 1'b0);
                        illegal = 1'b0;
                    end
                    F7_ALT: begin
                        if (funct3 == F3_ADD || funct3 == F3_SR) begin
                            alu_op  = base_op(funct3, 1'b1);
                            illegal = 1'b0;
                        end
                    end
                    F7_MEXT: begin
                        if (EN_M) begin
                            alu_op  = m_op(funct3);
                            is_m    = 1'b1;
                            illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else begin
                // Immediate forms: only the shifts constrain funct7, and ADDI never subtracts.
                if (funct3 == F3_SLL && funct7 != F7_BASE) begin
                    illegal = 1'b1;
                end else if (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT) begin
                    illegal = 1'b1;
                end else begin
                    alu_op  = base_op(funct3, (funct3 == F3_SR) && funct7[5]);
                    illegal = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rv32_aludec_pipe.sv
// Registered ALU decoder with a one-entry output buffer and start/done
// sequencing of M-extension ops to the mul/div unit under a watchdog.
module rv32_aludec_pipe
    import rv32_alu_pkg::*;
#(
    parameter bit EN_M       = 1'b1,
    parameter int MC_TIMEOUT = 64
) (
    input  logic [4:0]          LOGISIM_CLOCK_TREE_0,
    input  logic                reset,
    rv32_aludec_pipe_if.slave   bus
);

    localparam logic [7:0] CNT_LAST = 8'(MC_TIMEOUT - 1);

    logic       clk;
    logic       unused_clk_tree;
    state_t     state;
    logic [7:0] wait_cnt;
    alu_op_t    dec_op;
    logic       dec_is_m;
    logic       dec_illegal;
    logic       accept;

    assign clk             = LOGISIM_CLOCK_TREE_0[4];
    assign unused_clk_tree = ^LOGISIM_CLOCK_TREE_0[3:0];

    rv32_aludec_comb #(.EN_M(EN_M)) u_dec (
        .ar        (bus.ar),
        .ar_i      (bus.ar_i),
        .br        (bus.br),
        .lui_auipc (bus.lui_auipc),
        .funct3    (bus.funct3),
        .funct7    (bus.funct7),
        .alu_op    (dec_op),
        .is_m      (dec_is_m),
        .illegal   (dec_illegal)
    );

    // A full buffer accepts only when it is being drained in the same cycle.
    assign bus.in_ready = !reset && ((state == ST_IDLE) || (state == ST_FULL && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            bus.out_valid  <= 1'b0;
            bus.alu_op     <= ALU_ADD;
            bus.op_rs2_imm <= 1'b0;
            bus.illegal    <= 1'b0;
            bus.mc_start   <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.mc_start <= 1'b0;
            case (state)
                ST_IDLE, ST_FULL: begin
                    if (accept) begin
                        bus.alu_op     <= dec_op;
                        bus.illegal    <= dec_illegal;
                        bus.op_rs2_imm <= bus.ar_i | bus.lui_auipc;
                        if (dec_is_m) begin
                            state         <= ST_MC_WAIT;
                            wait_cnt      <= '0;
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b1;
                            bus.mc_start  <= 1'b1;
                        end else begin
                            state         <= ST_FULL;
                            bus.out_valid <= 1'b1;
                        end
                    end else if (state == ST_FULL && bus.out_ready) begin
                        state         <= ST_IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                ST_MC_WAIT: begin
                    // Completion takes priority over a watchdog expiring in the same cycle.
                    if (bus.mc_done) begin
                        state         <= ST_FULL;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state         <= ST_FULL;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                        bus.alu_op    <= ALU_ILL;
                        bus.illegal   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_aludec_pipe.sv
// Directed bench for rv32_aludec_pipe: one instance with RV32M, one without,
// both fed the same requests; inputs change and outputs are checked on negedge.
module tb_rv32_aludec_pipe;
    import rv32_alu_pkg::*;

    localparam logic [3:0] C_AR  = 4'b1000;
    localparam logic [3:0] C_ARI = 4'b0100;
    localparam logic [3:0] C_BR  = 4'b0010;
    localparam logic [3:0] C_LUI = 4'b0001;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] clk_tree;
    int         vectors = 0;
    int         miscompares = 0;

    assign clk_tree = {clk, 4'b0000};
    always #5 clk = ~clk;

    rv32_aludec_pipe_if bus_m ();
    rv32_aludec_pipe_if bus_n ();

    rv32_aludec_pipe #(.EN_M(1'b1), .MC_TIMEOUT(8)) dut_m (
        .LOGISIM_CLOCK_TREE_0 (clk_tree),
        .reset                (reset),
        .bus                  (bus_m.slave)
    );

    rv32_aludec_pipe #(.EN_M(1'b0), .MC_TIMEOUT(8)) dut_n (
        .LOGISIM_CLOCK_TREE_0 (clk_tree),
        .reset                (reset),
        .bus                  (bus_n.slave)
    );

    assign bus_n.in_valid  = bus_m.in_valid;
    assign bus_n.ar        = bus_m.ar;
    assign bus_n.ar_i      = bus_m.ar_i;
    assign bus_n.br        = bus_m.br;
    assign bus_n.lui_auipc = bus_m.lui_auipc;
    assign bus_n.funct3    = bus_m.funct3;
    assign bus_n.funct7    = bus_m.funct7;
    assign bus_n.out_ready = 1'b1;
    assign bus_n.mc_done   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [3:0] cls, input logic [2:0] f3, input logic [6:0] f7);
        {bus_m.ar, bus_m.ar_i, bus_m.br, bus_m.lui_auipc} = cls;
        bus_m.funct3   = f3;
        bus_m.funct7   = f7;
        bus_m.in_valid = 1'b1;
    endtask

    task automatic apply(input logic [3:0] cls, input logic [2:0] f3, input logic [6:0] f7);
        set_req(cls, f3, f7);
        tick();
        bus_m.in_valid = 1'b0;
    endtask

    task automatic dec_vec(input string tag, input logic [3:0] cls, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] exp_op, input logic exp_ill);
        apply(cls, f3, f7);
        check({tag, ".valid"},   bus_m.out_valid, 1);
        check({tag, ".op"},      bus_m.alu_op,    exp_op);
        check({tag, ".illegal"}, bus_m.illegal,   exp_ill);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset           = 1'b1;
        bus_m.in_valid  = 1'b0;
        bus_m.ar        = 1'b0;
        bus_m.ar_i      = 1'b0;
        bus_m.br        = 1'b0;
        bus_m.lui_auipc = 1'b0;
        bus_m.funct3    = 3'd0;
        bus_m.funct7    = 7'd0;
        bus_m.out_ready = 1'b1;
        bus_m.mc_done   = 1'b0;

        tick();
        check("rst.in_ready",  bus_m.in_ready,   0);
        check("rst.out_valid", bus_m.out_valid,  0);
        check("rst.alu_op",    bus_m.alu_op,     0);
        check("rst.busy",      bus_m.busy,       0);
        check("rst.mc_start",  bus_m.mc_start,   0);
        check("rst.illegal",   bus_m.illegal,    0);
        check("rst.imm",       bus_m.op_rs2_imm, 0);
        reset = 1'b0;
        #1;
        check("idle.in_ready", bus_m.in_ready, 1);

        dec_vec("sub", C_AR, 3'b000, F7_ALT, 5'd1, 1'b0);
        check("sub.imm", bus_m.op_rs2_imm, 0);
        check("sub.nom", bus_n.alu_op, 5'd1);
        dec_vec("addi", C_ARI, 3'b000, F7_ALT, 5'd0, 1'b0);
        check("addi.imm", bus_m.op_rs2_imm, 1);
        dec_vec("br010", C_BR, 3'b010, 7'd0, 5'd31, 1'b1);
        check("br010.mc_start", bus_m.mc_start, 0);
        check("br010.busy", bus_m.busy, 0);
        dec_vec("bgeu", C_BR, 3'b111, 7'd0, 5'd15, 1'b0);
        dec_vec("blt", C_BR, 3'b100, 7'd0, 5'd12, 1'b0);
        dec_vec("sra", C_AR, 3'b101, F7_ALT, 5'd7, 1'b0);
        dec_vec("sltu", C_AR, 3'b011, 7'd0, 5'd4, 1'b0);
        dec_vec("srli", C_ARI, 3'b101, 7'd0, 5'd6, 1'b0);
        dec_vec("srai", C_ARI, 3'b101, F7_ALT, 5'd7, 1'b0);
        dec_vec("slt_alt", C_AR, 3'b010, F7_ALT, 5'd31, 1'b1);
        dec_vec("slli_alt", C_ARI, 3'b001, F7_ALT, 5'd31, 1'b1);
        dec_vec("xori_f7", C_ARI, 3'b100, 7'h7f, 5'd5, 1'b0);
        dec_vec("ar_f7bad", C_AR, 3'b000, 7'b0000010, 5'd31, 1'b1);
        dec_vec("lui", C_LUI, 3'b011, 7'h55, 5'd0, 1'b0);
        check("lui.imm", bus_m.op_rs2_imm, 1);
        dec_vec("two_cls", C_AR | C_BR, 3'b000, 7'd0, 5'd31, 1'b1);
        dec_vec("no_cls", 4'b0000, 3'b000, 7'd0, 5'd31, 1'b1);
        tick();
        check("drain.valid", bus_m.out_valid, 0);

        // DIV with completion a few cycles after the start pulse
        apply(C_AR, 3'b100, F7_MEXT);
        check("div.mc_start", bus_m.mc_start, 1);
        check("div.busy", bus_m.busy, 1);
        check("div.valid", bus_m.out_valid, 0);
        check("div.in_ready", bus_m.in_ready, 0);
        check("nom.valid", bus_n.out_valid, 1);
        check("nom.op", bus_n.alu_op, 5'd31);
        check("nom.illegal", bus_n.illegal, 1);
        check("nom.mc_start", bus_n.mc_start, 0);
        tick();
        check("div.pulse_end", bus_m.mc_start, 0);
        check("div.busy2", bus_m.busy, 1);
        tick();
        tick();
        tick();
        check("div.waiting", {bus_m.busy, bus_m.out_valid}, 2'b10);
        bus_m.mc_done = 1'b1;
        tick();
        bus_m.mc_done = 1'b0;
        check("div.done_valid", bus_m.out_valid, 1);
        check("div.done_op", bus_m.alu_op, 5'd20);
        check("div.done_ill", bus_m.illegal, 0);
        check("div.done_busy", bus_m.busy, 0);
        tick();
        check("div.drain", bus_m.out_valid, 0);

        bus_m.mc_done = 1'b1;
        tick();
        bus_m.mc_done = 1'b0;
        check("stray_done.valid", bus_m.out_valid, 0);
        check("stray_done.busy", bus_m.busy, 0);

        // Watchdog expiry: result appears 8 cycles after the mc_start cycle
        apply(C_AR, 3'b100, F7_MEXT);
        check("to.mc_start", bus_m.mc_start, 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("to.wait%0d", i), {bus_m.busy, bus_m.out_valid}, 2'b10);
        end
        tick();
        check("to.valid", bus_m.out_valid, 1);
        check("to.op", bus_m.alu_op, 5'd31);
        check("to.illegal", bus_m.illegal, 1);
        check("to.busy", bus_m.busy, 0);
        tick();

        // Completion in the last watchdog cycle beats the timeout
        apply(C_AR, 3'b100, F7_MEXT);
        for (int i = 1; i < 8; i++) tick();
        bus_m.mc_done = 1'b1;
        tick();
        bus_m.mc_done = 1'b0;
        check("late_done.valid", bus_m.out_valid, 1);
        check("late_done.op", bus_m.alu_op, 5'd20);
        check("late_done.ill", bus_m.illegal, 0);
        tick();

        // Backpressure with a pending request, then back-to-back release
        bus_m.out_ready = 1'b0;
        set_req(C_AR, 3'b110, 7'd0);
        tick();
        set_req(C_AR, 3'b111, 7'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), bus_m.in_ready, 0);
            check($sformatf("bp%0d.valid", i), bus_m.out_valid, 1);
            check($sformatf("bp%0d.op", i), bus_m.alu_op, 5'd8);
            tick();
        end
        bus_m.out_ready = 1'b1;
        #1;
        check("bp.release_ready", bus_m.in_ready, 1);
        tick();
        check("bp.and_valid", bus_m.out_valid, 1);
        check("bp.and_op", bus_m.alu_op, 5'd9);
        set_req(C_AR, 3'b001, 7'd0);
        tick();
        bus_m.in_valid = 1'b0;
        check("bp.sll_op", bus_m.alu_op, 5'd2);
        check("bp.sll_valid", bus_m.out_valid, 1);
        tick();
        check("bp.drain", bus_m.out_valid, 0);

        // Asynchronous reset while waiting on the mul/div unit
        apply(C_AR, 3'b100, F7_MEXT);
        check("ra.busy", bus_m.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ra.valid", bus_m.out_valid, 0);
        check("ra.op", bus_m.alu_op, 0);
        check("ra.busy0", bus_m.busy, 0);
        check("ra.mc_start", bus_m.mc_start, 0);
        check("ra.illegal", bus_m.illegal, 0);
        check("ra.in_ready", bus_m.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("ra.after_valid", bus_m.out_valid, 0);
        check("ra.after_busy", bus_m.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
